// File: rtl/traffic_intersection_ctrl_if.sv
// Run-control inputs and lamp outputs of the intersection controller.
// master drives the requests; slave is the controller itself.

interface traffic_intersection_ctrl_if #(
    parameter int unsigned NUM_DIR = 2
);
    localparam int unsigned DIR_W = $clog2(NUM_DIR);

    logic               enable;
    logic               flash_mode;
    logic [NUM_DIR-1:0] ped_req;
    logic [NUM_DIR-1:0] red;
    logic [NUM_DIR-1:0] yellow;
    logic [NUM_DIR-1:0] green;
    logic [NUM_DIR-1:0] walk;
    logic [DIR_W-1:0]   active_dir;

    modport master (
        output enable, flash_mode, ped_req,
        input  red, yellow, green, walk, active_dir
    );

    modport slave (
        input  enable, flash_mode, ped_req,
        output red, yellow, green, walk, active_dir
    );
endinterface

// File: rtl/traffic_intersection_ctrl.sv
// Round-robin multi-approach traffic-light controller with latched pedestrian
// walk requests, safe shutdown on enable loss and flashing-yellow maintenance.

module traffic_intersection_ctrl #(
    parameter int unsigned NUM_DIR       = 2,
    parameter int unsigned GREEN_CYCLES  = 20,
    parameter int unsigned YELLOW_CYCLES = 7,
    parameter int unsigned ALLRED_CYCLES = 2,
    parameter int unsigned FLASH_HALF    = 8,
    parameter int unsigned CNT_W         = 8
) (
    input  logic                         clk,
    input  logic                         reset_n,
    traffic_intersection_ctrl_if.slave   bus
);
    localparam int unsigned DIR_W = $clog2(NUM_DIR);

    localparam logic [CNT_W-1:0] GREEN_LOAD  = CNT_W'(GREEN_CYCLES - 1);
    localparam logic [CNT_W-1:0] YELLOW_LOAD = CNT_W'(YELLOW_CYCLES - 1);
    localparam logic [CNT_W-1:0] ALLRED_LOAD = CNT_W'(ALLRED_CYCLES - 1);
    localparam logic [CNT_W-1:0] FLASH_LOAD  = CNT_W'(FLASH_HALF - 1);
    localparam logic [DIR_W-1:0] LAST_DIR    = DIR_W'(NUM_DIR - 1);

    typedef enum logic [2:0] {
        IDLE,
        GREEN,
        YELLOW,
        ALLRED,
        FLASH
    } state_t;

    state_t             state, state_nxt;
    logic [CNT_W-1:0]   cnt, cnt_nxt;
    logic [DIR_W-1:0]   dir, dir_nxt;
    logic               flash_on, flash_on_nxt;
    logic               from_flash, from_flash_nxt;
    logic               enter_green;
    logic               stop_req;

    logic [NUM_DIR-1:0] dir_sel;
    logic [NUM_DIR-1:0] ped_latch, ped_latch_nxt;
    logic [NUM_DIR-1:0] walk_q, walk_nxt;
    logic [NUM_DIR-1:0] red_q, red_nxt;
    logic [NUM_DIR-1:0] yellow_q, yellow_nxt;
    logic [NUM_DIR-1:0] green_q, green_nxt;

    assign stop_req = bus.flash_mode || !bus.enable;

    // State, phase counter and lamp registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= IDLE;
            cnt        <= '0;
            dir        <= '0;
            flash_on   <= 1'b0;
            from_flash <= 1'b0;
            ped_latch  <= '0;
            walk_q     <= '0;
            red_q      <= '1;
            yellow_q   <= '0;
            green_q    <= '0;
        end else begin
            state      <= state_nxt;
            cnt        <= cnt_nxt;
            dir        <= dir_nxt;
            flash_on   <= flash_on_nxt;
            from_flash <= from_flash_nxt;
            ped_latch  <= ped_latch_nxt;
            walk_q     <= walk_nxt;
            red_q      <= red_nxt;
            yellow_q   <= yellow_nxt;
            green_q    <= green_nxt;
        end
    end

    // Next-state, phase counter and served-approach sequencing
    always_comb begin
        state_nxt      = state;
        cnt_nxt        = cnt;
        dir_nxt        = dir;
        flash_on_nxt   = flash_on;
        from_flash_nxt = from_flash;
        enter_green    = 1'b0;

        case (state)
            IDLE: begin
                if (bus.flash_mode) begin
                    state_nxt    = FLASH;
                    cnt_nxt      = FLASH_LOAD;
                    flash_on_nxt = 1'b1;
                end else if (bus.enable) begin
                    state_nxt   = GREEN;
                    cnt_nxt     = GREEN_LOAD;
                    enter_green = 1'b1;
                end
            end

            GREEN: begin
                if (stop_req || cnt == '0) begin
                    state_nxt = YELLOW;
                    cnt_nxt   = YELLOW_LOAD;
                end else begin
                    cnt_nxt = cnt - CNT_W'(1);
                end
            end

            YELLOW: begin
                if (cnt == '0) begin
                    state_nxt      = ALLRED;
                    cnt_nxt        = ALLRED_LOAD;
                    from_flash_nxt = 1'b0;
                end else begin
                    cnt_nxt = cnt - CNT_W'(1);
                end
            end

            ALLRED: begin
                if (cnt != '0) begin
                    cnt_nxt = cnt - CNT_W'(1);
                end else if (bus.flash_mode) begin
                    // Maintenance keeps the interrupted approach as the one to resume
                    state_nxt    = FLASH;
                    cnt_nxt      = FLASH_LOAD;
                    flash_on_nxt = 1'b1;
                end else begin
                    if (!from_flash) begin
                        dir_nxt = (dir == LAST_DIR) ? '0 : dir + DIR_W'(1);
                    end
                    if (bus.enable) begin
                        state_nxt   = GREEN;
                        cnt_nxt     = GREEN_LOAD;
                        enter_green = 1'b1;
                    end else begin
                        state_nxt = IDLE;
                    end
                end
            end

            FLASH: begin
                if (!bus.flash_mode) begin
                    state_nxt      = ALLRED;
                    cnt_nxt        = ALLRED_LOAD;
                    from_flash_nxt = 1'b1;
                    flash_on_nxt   = 1'b0;
                end else if (cnt == '0) begin
                    cnt_nxt      = FLASH_LOAD;
                    flash_on_nxt = !flash_on;
                end else begin
                    cnt_nxt = cnt - CNT_W'(1);
                end
            end

            default: begin
                state_nxt = IDLE;
                cnt_nxt   = '0;
            end
        endcase
    end

    // One-hot select of the approach served after this edge
    always_comb begin
        dir_sel = '0;
        for (int i = 0; i < NUM_DIR; i++) begin
            dir_sel[i] = (dir_nxt == DIR_W'(i));
        end
    end

    // Pedestrian latches, walk and lamp decode of the next state
    always_comb begin
        ped_latch_nxt = ped_latch | ((state == FLASH) ? '0 : bus.ped_req);
        walk_nxt      = walk_q;
        red_nxt       = '1;
        yellow_nxt    = '0;
        green_nxt     = '0;

        // A request arriving on the entry edge is served in this turn
        if (enter_green) begin
            walk_nxt      = ped_latch_nxt & dir_sel;
            ped_latch_nxt = ped_latch_nxt & ~dir_sel;
        end else if (state_nxt != GREEN) begin
            walk_nxt = '0;
        end

        case (state_nxt)
            GREEN: begin
                green_nxt = dir_sel;
                red_nxt   = ~dir_sel;
            end
            YELLOW: begin
                yellow_nxt = dir_sel;
                red_nxt    = ~dir_sel;
            end
            FLASH: begin
                red_nxt    = '0;
                yellow_nxt = {NUM_DIR{flash_on_nxt}};
            end
            default: begin
                red_nxt = '1;
            end
        endcase
    end

    assign bus.red        = red_q;
    assign bus.yellow     = yellow_q;
    assign bus.green      = green_q;
    assign bus.walk       = walk_q;
    assign bus.active_dir = dir;

endmodule

// File: tb/tb_traffic_intersection_ctrl.sv
// Scoreboard bench: per-cycle lamp expectations are queued with the stimulus
// and compared one entry per clock against two controller configurations.

module tb_traffic_intersection_ctrl;

    localparam int K_G  = 0;
    localparam int K_Y  = 1;
    localparam int K_R  = 2;
    localparam int K_F1 = 3;
    localparam int K_F0 = 4;

    typedef struct {
        bit         dut;
        logic [2:0] red;
        logic [2:0] yellow;
        logic [2:0] green;
        logic [2:0] walk;
        logic [1:0] ad;
    } exp_t;

    logic clk;
    logic reset_n;
    logic reset_b;

    int checks = 0;
    int errors = 0;

    exp_t sb_q[$];

    traffic_intersection_ctrl_if #(.NUM_DIR(3)) bus_a ();
    traffic_intersection_ctrl_if #(.NUM_DIR(2)) bus_b ();

    traffic_intersection_ctrl #(
        .NUM_DIR(3), .GREEN_CYCLES(4), .YELLOW_CYCLES(2), .ALLRED_CYCLES(1),
        .FLASH_HALF(3), .CNT_W(8)
    ) dut_a (
        .clk(clk), .reset_n(reset_n), .bus(bus_a)
    );

    traffic_intersection_ctrl #(
        .NUM_DIR(2), .GREEN_CYCLES(1), .YELLOW_CYCLES(1), .ALLRED_CYCLES(1),
        .FLASH_HALF(1), .CNT_W(4)
    ) dut_b (
        .clk(clk), .reset_n(reset_b), .bus(bus_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, want, $time);
        end
    endtask

    // Queue n cycles of one lamp pattern for approach d
    task automatic push(input bit dut, input int n, input int kind, input int d, input logic [2:0] w);
        exp_t e;
        logic [2:0] all;
        logic [2:0] sel;
        all = dut ? 3'b011 : 3'b111;
        sel = 3'(1 << d);
        e.dut = dut;
        e.ad = 2'(d);
        e.walk = w;
        e.red = '0;
        e.yellow = '0;
        e.green = '0;
        case (kind)
            K_G: begin e.green = sel; e.red = all & ~sel; end
            K_Y: begin e.yellow = sel; e.red = all & ~sel; end
            K_R: e.red = all;
            K_F1: e.yellow = all;
            default: ;
        endcase
        for (int i = 0; i < n; i++) sb_q.push_back(e);
    endtask

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    // Compare one queued expectation per clock, 1 time unit after the edge
    initial begin
        exp_t e;
        logic [2:0] r, y, g, w;
        logic [1:0] ad;
        forever begin
            @(posedge clk);
            #1;
            if (sb_q.size() > 0) begin
                e = sb_q.pop_front();
                if (e.dut) begin
                    r = {1'b0, bus_b.red};
                    y = {1'b0, bus_b.yellow};
                    g = {1'b0, bus_b.green};
                    w = {1'b0, bus_b.walk};
                    ad = {1'b0, bus_b.active_dir};
                end else begin
                    r = bus_a.red;
                    y = bus_a.yellow;
                    g = bus_a.green;
                    w = bus_a.walk;
                    ad = bus_a.active_dir;
                end
                check(e.dut ? "B red" : "A red", 32'(r), 32'(e.red));
                check(e.dut ? "B yellow" : "A yellow", 32'(y), 32'(e.yellow));
                check(e.dut ? "B green" : "A green", 32'(g), 32'(e.green));
                check(e.dut ? "B walk" : "A walk", 32'(w), 32'(e.walk));
                check(e.dut ? "B active_dir" : "A active_dir", 32'(ad), 32'(e.ad));
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset_n = 1'b0;
        reset_b = 1'b0;
        bus_a.enable = 1'b0;
        bus_a.flash_mode = 1'b0;
        bus_a.ped_req = '0;
        bus_b.enable = 1'b1;
        bus_b.flash_mode = 1'b0;
        bus_b.ped_req = '0;

        // Reset held, then idle with enable low
        push(0, 3, K_R, 0, 3'b000);
        cyc(3);
        reset_n = 1'b1;
        push(0, 2, K_R, 0, 3'b000);
        cyc(2);

        // Main rotation, pedestrian, enable-loss and flash scenario (entries 0..105)
        bus_a.enable = 1'b1;
        push(0, 4, K_G, 0, 3'b000); push(0, 2, K_Y, 0, 3'b000); push(0, 1, K_R, 0, 3'b000);
        push(0, 4, K_G, 1, 3'b000); push(0, 2, K_Y, 1, 3'b000); push(0, 1, K_R, 1, 3'b000);
        push(0, 4, K_G, 2, 3'b100); push(0, 2, K_Y, 2, 3'b000); push(0, 1, K_R, 2, 3'b000);
        push(0, 4, K_G, 0, 3'b000); push(0, 2, K_Y, 0, 3'b000); push(0, 1, K_R, 0, 3'b000);
        push(0, 4, K_G, 1, 3'b000); push(0, 2, K_Y, 1, 3'b000); push(0, 1, K_R, 1, 3'b000);
        push(0, 4, K_G, 2, 3'b100); push(0, 2, K_Y, 2, 3'b000); push(0, 1, K_R, 2, 3'b000);
        push(0, 4, K_G, 0, 3'b000); push(0, 2, K_Y, 0, 3'b000); push(0, 1, K_R, 0, 3'b000);
        push(0, 2, K_G, 1, 3'b000); push(0, 2, K_Y, 1, 3'b000); push(0, 1, K_R, 1, 3'b000);
        push(0, 2, K_R, 2, 3'b000);
        push(0, 4, K_G, 2, 3'b000); push(0, 2, K_Y, 2, 3'b000); push(0, 1, K_R, 2, 3'b000);
        push(0, 4, K_G, 0, 3'b000); push(0, 2, K_Y, 0, 3'b000); push(0, 1, K_R, 0, 3'b000);
        push(0, 2, K_G, 1, 3'b000); push(0, 2, K_Y, 1, 3'b000); push(0, 1, K_R, 1, 3'b000);
        push(0, 3, K_F1, 1, 3'b000); push(0, 3, K_F0, 1, 3'b000);
        push(0, 3, K_F1, 1, 3'b000); push(0, 2, K_F0, 1, 3'b000);
        push(0, 1, K_R, 1, 3'b000);
        push(0, 4, K_G, 1, 3'b000); push(0, 2, K_Y, 1, 3'b000); push(0, 1, K_R, 1, 3'b000);
        push(0, 4, K_G, 2, 3'b000); push(0, 2, K_Y, 2, 3'b000); push(0, 1, K_R, 2, 3'b000);
        push(0, 4, K_G, 0, 3'b000); push(0, 1, K_Y, 0, 3'b000);

        cyc(1);  bus_a.ped_req = 3'b100;
        cyc(1);  bus_a.ped_req = 3'b000;
        cyc(13); bus_a.ped_req = 3'b100;
        cyc(1);  bus_a.ped_req = 3'b000;
        cyc(35); bus_a.enable = 1'b0;
        cyc(5);  bus_a.enable = 1'b1;
        cyc(16); bus_a.flash_mode = 1'b1;
        cyc(4);  bus_a.ped_req = 3'b011;
        cyc(1);  bus_a.ped_req = 3'b000;
        cyc(9);  bus_a.flash_mode = 1'b0;
        cyc(16); bus_a.ped_req = 3'b010;
        cyc(1);  bus_a.ped_req = 3'b000;
        cyc(3);

        // Asynchronous reset in the middle of yellow[0], checked before any edge
        #1;
        reset_n = 1'b0;
        #1;
        check("async_rst red", 32'(bus_a.red), 32'h7);
        check("async_rst yellow", 32'(bus_a.yellow), 32'h0);
        check("async_rst green", 32'(bus_a.green), 32'h0);
        check("async_rst walk", 32'(bus_a.walk), 32'h0);
        check("async_rst active_dir", 32'(bus_a.active_dir), 32'h0);
        bus_a.enable = 1'b0;
        push(0, 2, K_R, 0, 3'b000);
        cyc(2);

        // After reset the pending walk request for approach 1 is gone
        reset_n = 1'b1;
        bus_a.enable = 1'b1;
        push(0, 4, K_G, 0, 3'b000); push(0, 2, K_Y, 0, 3'b000); push(0, 1, K_R, 0, 3'b000);
        push(0, 4, K_G, 1, 3'b000);
        cyc(11);
        bus_a.enable = 1'b0;

        // Two approaches with single-cycle phases: wrap, walk, flash with half-period 1
        push(1, 2, K_R, 0, 3'b000);
        cyc(2);
        reset_b = 1'b1;
        push(1, 1, K_G, 0, 3'b000); push(1, 1, K_Y, 0, 3'b000); push(1, 1, K_R, 0, 3'b000);
        push(1, 1, K_G, 1, 3'b010); push(1, 1, K_Y, 1, 3'b000); push(1, 1, K_R, 1, 3'b000);
        push(1, 1, K_G, 0, 3'b000); push(1, 1, K_Y, 0, 3'b000); push(1, 1, K_R, 0, 3'b000);
        push(1, 1, K_F1, 0, 3'b000); push(1, 1, K_F0, 0, 3'b000); push(1, 1, K_F1, 0, 3'b000);
        push(1, 1, K_R, 0, 3'b000); push(1, 1, K_G, 0, 3'b000); push(1, 1, K_Y, 0, 3'b000);
        cyc(1); bus_b.ped_req = 2'b10;
        cyc(1); bus_b.ped_req = 2'b00;
        cyc(7); bus_b.flash_mode = 1'b1;
        cyc(3); bus_b.flash_mode = 1'b0;
        cyc(3);

        check("queue_drained", 32'(sb_q.size()), 32'h0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
